// File: rtl/stream_led_multi_if.sv
// Control and LED-bank signals of the multi-pattern running-light engine.
// The master drives mode/speed/pause; the engine (slave) drives the LED bank and strobes.
interface stream_led_multi_if #(
    parameter int N_LED = 8
);
    logic [1:0]       mode;
    logic [1:0]       speed;
    logic             pause;
    logic [N_LED-1:0] led_io;
    logic             tick;
    logic             wrap;

    modport master (
        output mode, speed, pause,
        input  led_io, tick, wrap
    );

    modport slave (
        input  mode, speed, pause,
        output led_io, tick, wrap
    );
endinterface

// File: rtl/stream_led_multi.sv
// Multi-pattern running-light engine: tick divider with speed select and pause,
// four patterns (LEFT, RIGHT, BOUNCE, FILL) whose switches take effect on a tick.
module stream_led_multi #(
    parameter int N_LED   = 8,
    parameter int DIV_CNT = 5_000_000
) (
    input  logic               clk,
    input  logic               reset,
    stream_led_multi_if.slave  bus
);
    localparam int CW  = $clog2(DIV_CNT * 8);
    localparam int CW1 = CW + 1;
    localparam logic [CW:0]      BASE       = CW1'(DIV_CNT);
    localparam logic [N_LED-1:0] INIT_LOW   = N_LED'(1);
    localparam logic [N_LED-1:0] INIT_HIGH  = N_LED'(1) << (N_LED - 1);
    localparam logic [N_LED-1:0] ALL_ONES   = '1;

    typedef enum logic [1:0] {
        LEFT   = 2'd0,
        RIGHT  = 2'd1,
        BOUNCE = 2'd2,
        FILL   = 2'd3
    } mode_e;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_e;

    logic [CW-1:0]    cnt;
    logic [CW:0]      limit;
    logic             at_limit;
    mode_e            act_mode;
    mode_e            req_mode;
    dir_e             dir;
    dir_e             nxt_dir;
    logic [N_LED-1:0] led;
    logic [N_LED-1:0] nxt_led;
    logic             nxt_wrap;
    logic             tick_q;
    logic             wrap_q;

    function automatic logic [N_LED-1:0] init_of(mode_e m);
        case (m)
            LEFT, BOUNCE: return INIT_LOW;
            RIGHT:        return INIT_HIGH;
            default:      return '0;
        endcase
    endfunction

    assign req_mode = mode_e'(bus.mode);

    // The compare uses >= so that lowering speed mid-count fires at once
    // instead of wrapping the counter all the way around.
    assign limit    = (BASE << bus.speed) - CW1'(1);
    assign at_limit = ({1'b0, cnt} >= limit);

    // NOTE: every output of an always_comb gets a default first; a branch that
    // forgets one would otherwise infer a latch.
    always_comb begin
        nxt_led  = led;
        nxt_dir  = dir;
        nxt_wrap = 1'b0;
        case (act_mode)
            LEFT: begin
                nxt_led  = {led[N_LED-2:0], led[N_LED-1]};
                nxt_wrap = (nxt_led == INIT_LOW);
            end
            RIGHT: begin
                nxt_led  = {led[0], led[N_LED-1:1]};
                nxt_wrap = (nxt_led == INIT_HIGH);
            end
            BOUNCE: begin
                if (dir == UP) begin
                    nxt_led = led << 1;
                    if (nxt_led[N_LED-1]) nxt_dir = DOWN;
                end else begin
                    nxt_led = led >> 1;
                    if (nxt_led[0]) nxt_dir = UP;
                end
                nxt_wrap = (nxt_led == INIT_LOW);
            end
            default: begin
                nxt_led  = (led == ALL_ONES) ? '0 : {led[N_LED-2:0], 1'b1};
                nxt_wrap = (nxt_led == '0);
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments and the asynchronous
    // reset, so every register here sees the same pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            act_mode <= LEFT;
            dir      <= UP;
            led      <= INIT_LOW;
            tick_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else if (bus.pause) begin
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else if (at_limit) begin
            cnt    <= '0;
            tick_q <= 1'b1;
            if (req_mode != act_mode) begin
                // A switch loads the new pattern's start and does not count as a wrap.
                act_mode <= req_mode;
                led      <= init_of(req_mode);
                dir      <= UP;
                wrap_q   <= 1'b0;
            end else begin
                led    <= nxt_led;
                dir    <= nxt_dir;
                wrap_q <= nxt_wrap;
            end
        end else begin
            cnt    <= cnt + 1'b1;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end
    end

    assign bus.led_io = led;
    assign bus.tick   = tick_q;
    assign bus.wrap   = wrap_q;
endmodule
